// File: rtl/progmem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : progmem_loader
//  Purpose  : Boot-time program memory writer. Receives a framed byte stream
//             (SYNC, ADDR_H, ADDR_L, CNT_H, CNT_L, CNT x {hi,lo}, CHK) over a
//             valid/ready handshake, writes big-endian 16-bit words into the
//             program memory and releases the CPU once a frame has loaded
//             with a matching checksum.
//  Ports    : clk, resetn        - clock, asynchronous active-low reset
//             in_data/in_valid   - byte stream input
//             in_ready           - byte accepted when in_valid & in_ready
//             mem_addr/mem_din   - progmem word address / write data
//             mem_we             - one-cycle write strobe per word
//             cpu_run            - CPU reset release
//             busy/done          - frame in progress / load complete (sticky)
//             error/err_code     - last frame failed: 01 range, 10 checksum,
//                                  11 timeout
//  Revision : 1.0 - initial release
// ============================================================================
module progmem_loader #(
  parameter int unsigned TIMEOUT = 50000,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_din,
  output logic        mem_we,
  output logic        cpu_run,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code
);

  // Counter only has to reach TIMEOUT-1 before the timeout fires.
  localparam int unsigned TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_ADDR_H = 4'd1;
  localparam logic [3:0] S_ADDR_L = 4'd2;
  localparam logic [3:0] S_CNT_H  = 4'd3;
  localparam logic [3:0] S_CNT_L  = 4'd4;
  localparam logic [3:0] S_DATA_H = 4'd5;
  localparam logic [3:0] S_DATA_L = 4'd6;
  localparam logic [3:0] S_WRITE  = 4'd7;
  localparam logic [3:0] S_CHK    = 4'd8;
  localparam logic [3:0] S_DONE   = 4'd9;

  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_CHK   = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  logic [3:0]       state_q, state_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [7:0]       hi_q, hi_d;
  logic [7:0]       sum_q, sum_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             error_q, error_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             mem_we_q, mem_we_d;
  logic [15:0]      mem_addr_q, mem_addr_d;
  logic [15:0]      mem_din_q, mem_din_d;

  logic             accept;
  logic             timed_state;
  logic [16:0]      end_addr;

  // Gating with resetn keeps in_ready low while reset is held even though
  // the state register already sits in IDLE.
  assign in_ready = resetn && (state_q != S_WRITE) && (state_q != S_DONE);
  assign accept   = in_valid && in_ready;

  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_we   = mem_we_q;
  assign cpu_run  = (state_q == S_DONE);
  assign done     = (state_q == S_DONE);
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign error    = error_q;
  assign err_code = err_code_q;

  // Last word address + 1 in 17 bits; exactly 17'h10000 is still in range.
  assign end_addr = {1'b0, addr_q} + {1'b0, cnt_q[15:8], in_data};

  // The inter-byte timer runs in every in-frame state except WRITE, where
  // the loader itself is holding off the source.
  assign timed_state = (state_q >= S_ADDR_H) && (state_q <= S_CHK) &&
                       (state_q != S_WRITE);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    sum_d      = sum_q;
    tmo_d      = tmo_q;
    error_d    = error_q;
    err_code_d = err_code_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;

    if (timed_state) begin
      tmo_d = accept ? '0 : tmo_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (accept && (in_data == SYNC)) begin
          error_d    = 1'b0;
          err_code_d = 2'b00;
          sum_d      = 8'h00;
          tmo_d      = '0;
          state_d    = S_ADDR_H;
        end
      end
      S_ADDR_H: begin
        if (accept) begin
          addr_d[15:8] = in_data;
          sum_d        = sum_q + in_data;
          state_d      = S_ADDR_L;
        end
      end
      S_ADDR_L: begin
        if (accept) begin
          addr_d[7:0] = in_data;
          sum_d       = sum_q + in_data;
          state_d     = S_CNT_H;
        end
      end
      S_CNT_H: begin
        if (accept) begin
          cnt_d[15:8] = in_data;
          sum_d       = sum_q + in_data;
          state_d     = S_CNT_L;
        end
      end
      S_CNT_L: begin
        if (accept) begin
          cnt_d[7:0] = in_data;
          sum_d      = sum_q + in_data;
          if (end_addr > 17'h10000) begin
            error_d    = 1'b1;
            err_code_d = ERR_RANGE;
            state_d    = S_IDLE;
          end else if ({cnt_q[15:8], in_data} == 16'h0000) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA_H;
          end
        end
      end
      S_DATA_H: begin
        if (accept) begin
          hi_d    = in_data;
          sum_d   = sum_q + in_data;
          state_d = S_DATA_L;
        end
      end
      S_DATA_L: begin
        // Write port is loaded here so it is valid for exactly the WRITE
        // cycle and otherwise holds its last value.
        if (accept) begin
          sum_d      = sum_q + in_data;
          mem_we_d   = 1'b1;
          mem_addr_d = addr_q;
          mem_din_d  = {hi_q, in_data};
          state_d    = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + 16'd1;
        cnt_d   = cnt_q - 16'd1;
        state_d = (cnt_q == 16'd1) ? S_CHK : S_DATA_H;
      end
      S_CHK: begin
        if (accept) begin
          if (in_data == sum_q) begin
            state_d = S_DONE;
          end else begin
            error_d    = 1'b1;
            err_code_d = ERR_CHK;
            state_d    = S_IDLE;
          end
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Only reachable on a cycle with no accepted byte, so it never collides
    // with a transition taken by the case above.
    if (timed_state && !accept && (tmo_q == TMO_LAST)) begin
      error_d    = 1'b1;
      err_code_d = ERR_TMO;
      tmo_d      = '0;
      state_d    = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      addr_q     <= 16'h0000;
      cnt_q      <= 16'h0000;
      hi_q       <= 8'h00;
      sum_q      <= 8'h00;
      tmo_q      <= '0;
      error_q    <= 1'b0;
      err_code_q <= 2'b00;
      mem_we_q   <= 1'b0;
      mem_addr_q <= 16'h0000;
      mem_din_q  <= 16'h0000;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      sum_q      <= sum_d;
      tmo_q      <= tmo_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_progmem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_progmem_loader
//  Purpose  : Directed bench for progmem_loader. Expected writes are queued
//             as each data word is driven and popped by a write monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_progmem_loader;

  logic        clk;
  logic        resetn;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_we;
  logic        cpu_run;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] exp_q[$];   // {addr, data} of writes still to be seen
  logic [15:0] wq[$];      // payload words for send_frame
  bit          throttle = 0;

  progmem_loader #(.TIMEOUT(20), .SYNC(8'hA5)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_we   (mem_we),
    .cpu_run  (cpu_run),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_code (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_chk++;
    assert (obs === req) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
  endtask

  // Write monitor: every strobe must match the oldest queued write; while
  // running and not done, in_ready must be low exactly on write cycles.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (done !== 1'b1) check("ready_vs_we", {31'd0, in_ready}, {31'd0, ~mem_we});
      if (mem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $error("FAIL unexpected_write: observed %h<=%h expected none", mem_addr, mem_din);
        end else begin
          check("write", {mem_addr, mem_din}, exp_q.pop_front());
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input logic [7:0] b);
    int budget;
    if (throttle) repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
    in_data  = b;
    in_valid = 1'b1;
    budget   = 0;
    while (in_ready !== 1'b1) begin
      @(negedge clk);
      budget++;
      if (budget > 100) begin
        n_chk++;
        $error("FAIL send_stall: observed in_ready low, expected accept of %h", b);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Sends SYNC, header, the words in wq and the checksum (xor-corrupted by
  // chk_xor); queues the expected writes as each word is driven.
  task automatic send_frame(input logic [15:0] addr, input logic [7:0] chk_xor);
    logic [7:0]  sum;
    logic [15:0] cnt;
    cnt = 16'(wq.size());
    sum = addr[15:8] + addr[7:0] + cnt[15:8] + cnt[7:0];
    send(8'hA5);
    send(addr[15:8]);
    send(addr[7:0]);
    send(cnt[15:8]);
    send(cnt[7:0]);
    for (int i = 0; i < wq.size(); i++) begin
      sum = sum + wq[i][15:8] + wq[i][7:0];
      send(wq[i][15:8]);
      exp_q.push_back({addr + 16'(i), wq[i]});
      send(wq[i][7:0]);
    end
    send(sum ^ chk_xor);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_mem_we"},   {31'd0, mem_we},   32'd0);
    check({tag, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
    check({tag, "_mem_din"},  {16'd0, mem_din},  32'd0);
    check({tag, "_cpu_run"},  {31'd0, cpu_run},  32'd0);
    check({tag, "_busy"},     {31'd0, busy},     32'd0);
    check({tag, "_done"},     {31'd0, done},     32'd0);
    check({tag, "_error"},    {31'd0, error},    32'd0);
    check({tag, "_err_code"}, {30'd0, err_code}, 32'd0);
  endtask

  task automatic apply_reset();
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("ready_after_rst", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    apply_reset();

    // Noise in IDLE is discarded.
    send(8'h00);
    send(8'hFF);
    check("noise_busy",  {31'd0, busy},  32'd0);
    check("noise_error", {31'd0, error}, 32'd0);

    // Checksum failure: both writes land, then error 10.
    wq = '{16'h1234, 16'hABCD};
    send_frame(16'h0400, 8'h01);   // last byte C5
    check("chk_error",   {31'd0, error},    32'd1);
    check("chk_code",    {30'd0, err_code}, 32'd2);
    check("chk_cpu_run", {31'd0, cpu_run},  32'd0);
    check("chk_busy",    {31'd0, busy},     32'd0);
    check("chk_drained", exp_q.size(),      32'd0);

    // Range failure: FFFF + 2 overflows, no writes.
    send(8'hA5);
    check("sync_clears_error", {31'd0, error}, 32'd0);
    send(8'hFF); send(8'hFF); send(8'h00); send(8'h02);
    check("range_error", {31'd0, error},    32'd1);
    check("range_code",  {30'd0, err_code}, 32'd1);
    check("range_idle",  {31'd0, busy},     32'd0);

    // Timeout: stall after ADDR_L.
    send(8'hA5); send(8'h04); send(8'h00);
    repeat (15) @(posedge clk);
    #1;
    check("tmo_still_busy", {31'd0, busy},  32'd1);
    check("tmo_not_yet",    {31'd0, error}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("tmo_error", {31'd0, error},    32'd1);
    check("tmo_code",  {30'd0, err_code}, 32'd3);
    check("tmo_busy",  {31'd0, busy},     32'd0);

    // Nominal frame under random throttling: A5 04 00 00 02 12 34 AB CD C4.
    throttle = 1;
    wq = '{16'h1234, 16'hABCD};
    send_frame(16'h0400, 8'h00);
    throttle = 0;
    check("nom_done",    {31'd0, done},    32'd1);
    check("nom_cpu_run", {31'd0, cpu_run}, 32'd1);
    check("nom_error",   {31'd0, error},   32'd0);
    check("nom_drained", exp_q.size(),     32'd0);

    // DONE ignores input.
    in_data  = 8'hA5;
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("done_ready", {31'd0, in_ready}, 32'd0);
    check("done_stuck", {31'd0, done},     32'd1);
    in_valid = 1'b0;

    // FFFF with count 1 is legal; sum FF+FF+00+01+DE+AD = 8A.
    apply_reset();
    exp_q.push_back({16'hFFFF, 16'hDEAD});
    send(8'hA5); send(8'hFF); send(8'hFF); send(8'h00); send(8'h01);
    send(8'hDE); send(8'hAD); send(8'h8A);
    check("top_done",    {31'd0, done},  32'd1);
    check("top_error",   {31'd0, error}, 32'd0);
    check("top_drained", exp_q.size(),   32'd0);

    // Zero-count frame: checksum over the header only.
    apply_reset();
    wq = {};
    send_frame(16'h1234, 8'h00);
    check("zero_done", {31'd0, done}, 32'd1);

    // Reset while in DATA_L of the second word.
    apply_reset();
    send(8'hA5); send(8'h04); send(8'h00); send(8'h00); send(8'h02);
    send(8'h12);
    exp_q.push_back({16'h0400, 16'h1234});
    send(8'h34);
    send(8'hAB);
    check("mid_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check_reset_values("mid");
    check("mid_drained", exp_q.size(), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    wq = '{16'h1234, 16'hABCD};
    send_frame(16'h0400, 8'h00);
    check("reload_done",    {31'd0, done},    32'd1);
    check("reload_drained", exp_q.size(),     32'd0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
